// File: rtl/slow2fast_multi_edge_detect.sv
// Multi-channel slow-to-fast level synchroniser with per-channel edge events, saturating counters and sticky flags.
// Define GLITCH_FILTER_EN to insert a FILT_LEN-cycle stability filter between the synchroniser and data_to_fast.
module slow2fast_multi_edge_detect #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int FILT_LEN    = 4
) (
    input  logic                clk_fast,
    input  logic                rst_n,
    input  logic [CH-1:0]       data_from_slow,
    input  logic [2*CH-1:0]     edge_mode,
    input  logic [CH-1:0]       cnt_clr,
    input  logic [CH-1:0]       sticky_clr,
    output logic [CH-1:0]       data_to_fast,
    output logic [CH-1:0]       edge_pulse,
    output logic [CH*CNT_W-1:0] edge_cnt,
    output logic [CH-1:0]       edge_sticky,
    output logic                irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CH-1:0][SYNC_STAGES-1:0] sync_reg;
    logic [CH-1:0]                  sync_out;
    logic [CH-1:0]                  level;
    logic [CH-1:0]                  prev_reg;
    logic [CH-1:0]                  event_hit;
    logic [CH-1:0]                  pulse_reg;
    logic [CH-1:0]                  sticky_reg;
    logic [CH-1:0]                  sticky_next;
    logic [CH-1:0][CNT_W-1:0]       cnt_reg;
    logic [CH-1:0][CNT_W-1:0]       cnt_next;

    genvar gi;

    generate
        for (gi = 0; gi < CH; gi++) begin : g_sync
            always_ff @(posedge clk_fast) begin
                if (!rst_n) begin
                    sync_reg[gi] <= '0;
                end else begin
                    sync_reg[gi] <= {sync_reg[gi][SYNC_STAGES-2:0], data_from_slow[gi]};
                end
            end
            assign sync_out[gi] = sync_reg[gi][SYNC_STAGES-1];
        end
    endgenerate

`ifdef GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(FILT_LEN + 1);

    logic [CH-1:0][FILT_W-1:0] filt_cnt_reg;
    logic [CH-1:0][FILT_W-1:0] filt_cnt_next;
    logic [CH-1:0]             level_reg;
    logic [CH-1:0]             level_next;

    generate
        for (gi = 0; gi < CH; gi++) begin : g_filt
            // The level only follows the synchroniser after FILT_LEN consecutive differing cycles.
            always_comb begin
                filt_cnt_next[gi] = '0;
                level_next[gi]    = level_reg[gi];
                if (sync_out[gi] != level_reg[gi]) begin
                    if (filt_cnt_reg[gi] == FILT_W'(FILT_LEN - 1)) begin
                        level_next[gi] = sync_out[gi];
                    end else begin
                        filt_cnt_next[gi] = filt_cnt_reg[gi] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_fast) begin
                if (!rst_n) begin
                    filt_cnt_reg[gi] <= '0;
                    level_reg[gi]    <= 1'b0;
                end else begin
                    filt_cnt_reg[gi] <= filt_cnt_next[gi];
                    level_reg[gi]    <= level_next[gi];
                end
            end
        end
    endgenerate

    assign level = level_reg;
`else
    assign level = sync_out;
`endif

    assign data_to_fast = level;

    generate
        for (gi = 0; gi < CH; gi++) begin : g_chan
            // edge_mode bit 0 enables rising events, bit 1 enables falling events.
            assign event_hit[gi] = (edge_mode[2*gi]   &  level[gi] & ~prev_reg[gi])
                                 | (edge_mode[2*gi+1] & ~level[gi] &  prev_reg[gi]);

            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (cnt_clr[gi]) begin
                    cnt_next[gi] = event_hit[gi] ? CNT_W'(1) : '0;
                end else if (event_hit[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_next[gi] = cnt_reg[gi] + 1'b1;
                end
            end

            always_comb begin
                sticky_next[gi] = sticky_reg[gi];
                if (event_hit[gi]) begin
                    sticky_next[gi] = 1'b1;
                end else if (sticky_clr[gi]) begin
                    sticky_next[gi] = 1'b0;
                end
            end

            always_ff @(posedge clk_fast) begin
                if (!rst_n) begin
                    prev_reg[gi]   <= 1'b0;
                    pulse_reg[gi]  <= 1'b0;
                    cnt_reg[gi]    <= '0;
                    sticky_reg[gi] <= 1'b0;
                end else begin
                    prev_reg[gi]   <= level[gi];
                    pulse_reg[gi]  <= event_hit[gi];
                    cnt_reg[gi]    <= cnt_next[gi];
                    sticky_reg[gi] <= sticky_next[gi];
                end
            end

            assign edge_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
        end
    endgenerate

    assign edge_pulse  = pulse_reg;
    assign edge_sticky = sticky_reg;
    assign irq         = |sticky_reg;

endmodule

// File: tb/tb_slow2fast_multi_edge_detect.sv
// Directed self-checking bench for slow2fast_multi_edge_detect (CH=4, SYNC_STAGES=2, CNT_W=8).
// Latencies stretch by FILT_LEN when GLITCH_FILTER_EN is defined; the glitch scenario only runs in that build.
module tb_slow2fast_multi_edge_detect;

    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int CW   = 8;
    localparam int FLEN = 4;
`ifdef GLITCH_FILTER_EN
    localparam int FL = FLEN;
`else
    localparam int FL = 0;
`endif

    logic              clk_fast;
    logic              rst_n;
    logic [CH-1:0]     data_from_slow;
    logic [2*CH-1:0]   edge_mode;
    logic [CH-1:0]     cnt_clr;
    logic [CH-1:0]     sticky_clr;
    logic [CH-1:0]     data_to_fast;
    logic [CH-1:0]     edge_pulse;
    logic [CH*CW-1:0]  edge_cnt;
    logic [CH-1:0]     edge_sticky;
    logic              irq;

    int n_checks;
    int n_fail;
    int pulse_seen [CH];
    int wide_err;
    int dtf0_high;
    logic [CH-1:0] last_pulse;

    slow2fast_multi_edge_detect #(
        .CH(CH), .SYNC_STAGES(SS), .CNT_W(CW), .FILT_LEN(FLEN)
    ) dut (
        .clk_fast(clk_fast),
        .rst_n(rst_n),
        .data_from_slow(data_from_slow),
        .edge_mode(edge_mode),
        .cnt_clr(cnt_clr),
        .sticky_clr(sticky_clr),
        .data_to_fast(data_to_fast),
        .edge_pulse(edge_pulse),
        .edge_cnt(edge_cnt),
        .edge_sticky(edge_sticky),
        .irq(irq)
    );

    initial clk_fast = 1'b0;
    always #50 clk_fast = ~clk_fast;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge, tallying pulses and over-wide pulses.
    task automatic tick();
        @(posedge clk_fast);
        #1;
        for (int c = 0; c < CH; c++) begin
            if (edge_pulse[c]) begin
                pulse_seen[c]++;
                if (last_pulse[c]) wide_err++;
            end
        end
        last_pulse = edge_pulse;
        if (data_to_fast[0]) dtf0_high++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        for (int c = 0; c < CH; c++) pulse_seen[c] = 0;
        wide_err  = 0;
        dtf0_high = 0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        last_pulse     = '0;
        rst_n          = 1'b0;
        data_from_slow = '0;
        edge_mode      = 8'b01_00_11_01;  // ch3 rise, ch2 off, ch1 both, ch0 rise
        cnt_clr        = '0;
        sticky_clr     = '0;
        clear_stats();

        // Reset state
        ticks(3);
        check_val("rst_dtf",    32'(data_to_fast), 32'h0);
        check_val("rst_pulse",  32'(edge_pulse),   32'h0);
        check_val("rst_cnt",    edge_cnt,          32'h0);
        check_val("rst_sticky", 32'(edge_sticky),  32'h0);
        check_val("rst_irq",    32'(irq),          32'h0);
        rst_n = 1'b1;
        ticks(2);
        clear_stats();

        // Scenario 1: single rising edge on channel 0, exact latency and width
        data_from_slow[0] = 1'b1;
        ticks(1 + FL);
        check_val("s1_dtf_early", 32'(data_to_fast[0]), 32'h0);
        tick();
        check_val("s1_dtf",        32'(data_to_fast[0]), 32'h1);
        check_val("s1_pulse_early", 32'(edge_pulse[0]),  32'h0);
        tick();
        check_val("s1_pulse",  32'(edge_pulse[0]),  32'h1);
        check_val("s1_cnt",    32'(edge_cnt[7:0]),  32'h1);
        check_val("s1_sticky", 32'(edge_sticky[0]), 32'h1);
        check_val("s1_irq",    32'(irq),            32'h1);
        tick();
        check_val("s1_pulse_end", 32'(edge_pulse[0]), 32'h0);
        data_from_slow[0] = 1'b0;
        ticks(8 + FL);
        check_val("s1_no_fall_pulse", 32'(pulse_seen[0]),   32'h1);
        check_val("s1_cnt_after",     32'(edge_cnt[7:0]),   32'h1);
        check_val("s1_dtf_low",       32'(data_to_fast[0]), 32'h0);

        // Scenario 2: channel 1 both edges, channel 2 disabled
        clear_stats();
        data_from_slow[2:1] = 2'b11;
        ticks(5 + FL);
        data_from_slow[2:1] = 2'b00;
        ticks(8 + FL);
        check_val("s2_ch1_pulses", 32'(pulse_seen[1]),    32'd2);
        check_val("s2_ch1_cnt",    32'(edge_cnt[15:8]),   32'd2);
        check_val("s2_ch2_pulses", 32'(pulse_seen[2]),    32'd0);
        check_val("s2_ch2_cnt",    32'(edge_cnt[23:16]),  32'd0);
        check_val("s2_sticky",     32'(edge_sticky[2:1]), 32'b01);
        check_val("s2_width",      32'(wide_err),         32'd0);

        // Scenario 3: 300 rising edges saturate channel 3, then clear interactions
        clear_stats();
        for (int i = 0; i < 300; i++) begin
            data_from_slow[3] = 1'b1;
            ticks(3 + FL);
            data_from_slow[3] = 1'b0;
            ticks(3 + FL);
        end
        ticks(6 + FL);
        check_val("s3_pulses", 32'(pulse_seen[3]),   32'd300);
        check_val("s3_sat",    32'(edge_cnt[31:24]), 32'd255);
        data_from_slow[3] = 1'b1;
        ticks(2 + FL);
        cnt_clr[3] = 1'b1;
        tick();
        cnt_clr[3] = 1'b0;
        check_val("s3_clr_pulse", 32'(edge_pulse[3]),   32'h1);
        check_val("s3_clr_event", 32'(edge_cnt[31:24]), 32'd1);
        ticks(2);
        cnt_clr[3] = 1'b1;
        tick();
        cnt_clr[3] = 1'b0;
        check_val("s3_clr_alone", 32'(edge_cnt[31:24]), 32'd0);
        data_from_slow[3] = 1'b0;
        ticks(6 + FL);

        // Scenario 4: sticky set wins over clear, then clear and irq drop
        data_from_slow[0] = 1'b1;
        ticks(2 + FL);
        sticky_clr[0] = 1'b1;
        tick();
        sticky_clr[0] = 1'b0;
        check_val("s4_pulse",      32'(edge_pulse[0]),  32'h1);
        check_val("s4_set_wins",   32'(edge_sticky[0]), 32'h1);
        data_from_slow[0] = 1'b0;
        ticks(6 + FL);
        sticky_clr = 4'b1110;
        tick();
        sticky_clr = '0;
        check_val("s4_others_clr", 32'(edge_sticky), 32'b0001);
        check_val("s4_irq_held",   32'(irq),         32'h1);
        sticky_clr = 4'b0001;
        tick();
        sticky_clr = '0;
        check_val("s4_sticky_clr", 32'(edge_sticky), 32'h0);
        check_val("s4_irq_clr",    32'(irq),         32'h0);

        // Scenario 5: reset while an edge is inside the synchroniser
        data_from_slow[0] = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("s5_dtf",    32'(data_to_fast), 32'h0);
        check_val("s5_pulse",  32'(edge_pulse),   32'h0);
        check_val("s5_cnt",    edge_cnt,          32'h0);
        check_val("s5_sticky", 32'(edge_sticky),  32'h0);
        check_val("s5_irq",    32'(irq),          32'h0);
        ticks(2 + FL);
        check_val("s5_pulse_early", 32'(edge_pulse[0]), 32'h0);
        tick();
        check_val("s5_pulse_after", 32'(edge_pulse[0]), 32'h1);
        check_val("s5_cnt_after",   32'(edge_cnt[7:0]), 32'd1);
        data_from_slow[0] = 1'b0;
        ticks(8 + FL);

`ifdef GLITCH_FILTER_EN
        // Scenario 6: short glitch suppressed, stable level passes after the filter latency
        clear_stats();
        data_from_slow[0] = 1'b1;
        ticks(2);
        data_from_slow[0] = 1'b0;
        ticks(12);
        check_val("s6_glitch_dtf",   32'(dtf0_high),     32'd0);
        check_val("s6_glitch_pulse", 32'(pulse_seen[0]), 32'd0);
        data_from_slow[0] = 1'b1;
        ticks(2 + FLEN);
        check_val("s6_dtf",         32'(data_to_fast[0]), 32'h1);
        check_val("s6_pulse_early", 32'(edge_pulse[0]),   32'h0);
        data_from_slow[0] = 1'b0;
        tick();
        check_val("s6_pulse", 32'(edge_pulse[0]), 32'h1);
        ticks(12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
